// File: rtl/home_appliance_ctrl.sv
// home_appliance_ctrl: settings register file for two fridges, two air
// conditioners and two washing machines, each washing machine with its own
// run sequencer.
//
// Ports:
//   clk, rst         : clock and synchronous active-high reset.
//   s0..s5           : command selector. {s0,s1} picks the device, s2 the unit,
//                      {s3,s4} the function, and s5 is a qualifier.
//   inp              : value written to fridge and AC settings.
//   wash/rinse/spin/cloth : washing machine program load values.
//   fridge, AC and WM outputs : current register contents. All are registered.
//
// Build option:
//   AC_TIMER_EN : when defined, each actimer counts down once per cycle and
//                 clears the matching acfan when it reaches zero.
module home_appliance_ctrl #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s0,
  input  logic         s1,
  input  logic         s2,
  input  logic         s3,
  input  logic         s4,
  input  logic         s5,
  input  logic [W-1:0] inp,
  output logic [W-1:0] fgt1, frt1, fgc1, frc1,
  output logic [W-1:0] fgt2, frt2, fgc2, frc2,
  output logic         ice1, ice2,
  output logic [W-1:0] actemp1, accap1, acfan1, actimer1,
  output logic [W-1:0] actemp2, accap2, acfan2, actimer2,
  input  logic [W-1:0] wash, rinse, spin, cloth,
  output logic [W-1:0] wash_out_1, rinse_out_1, spin_out_1, cloth_out_1,
  output logic [W-1:0] wash_out_2, rinse_out_2, spin_out_2, cloth_out_2
);

  localparam int unsigned NU = 2;

  logic [W-1:0] fgt_q [NU], fgt_d [NU];
  logic [W-1:0] frt_q [NU], frt_d [NU];
  logic [W-1:0] fgc_q [NU], fgc_d [NU];
  logic [W-1:0] frc_q [NU], frc_d [NU];
  logic         ice_q [NU], ice_d [NU];
  logic [W-1:0] act_q [NU], act_d [NU];
  logic [W-1:0] acc_q [NU], acc_d [NU];
  logic [W-1:0] acf_q [NU], acf_d [NU];
  logic [W-1:0] actm_q[NU], actm_d[NU];
  logic [W-1:0] wsh_q [NU], wsh_d [NU];
  logic [W-1:0] rns_q [NU], rns_d [NU];
  logic [W-1:0] spn_q [NU], spn_d [NU];
  logic [W-1:0] clo_q [NU], clo_d [NU];
  logic         run_q [NU], run_d [NU];

  logic [1:0] dev;
  logic [1:0] fn;
  assign dev = {s0, s1};
  assign fn  = {s3, s4};

  // Next-state: autonomous counting first, then the command overrides it.
  always_comb begin
    for (int u = 0; u < NU; u++) begin
      fgt_d[u]  = fgt_q[u];
      frt_d[u]  = frt_q[u];
      fgc_d[u]  = fgc_q[u];
      frc_d[u]  = frc_q[u];
      ice_d[u]  = ice_q[u];
      act_d[u]  = act_q[u];
      acc_d[u]  = acc_q[u];
      acf_d[u]  = acf_q[u];
      actm_d[u] = actm_q[u];
      wsh_d[u]  = wsh_q[u];
      rns_d[u]  = rns_q[u];
      spn_d[u]  = spn_q[u];
      clo_d[u]  = clo_q[u];
      run_d[u]  = run_q[u];
    end

    // WM sequencer: drain wash, then rinse, then spin; done when all are zero.
    for (int u = 0; u < NU; u++) begin
      if (run_q[u]) begin
        if (wsh_q[u] != '0)      wsh_d[u] = wsh_q[u] - W'(1);
        else if (rns_q[u] != '0) rns_d[u] = rns_q[u] - W'(1);
        else if (spn_q[u] != '0) spn_d[u] = spn_q[u] - W'(1);
        else                     run_d[u] = 1'b0;
      end
    end

`ifdef AC_TIMER_EN
    // AC timer countdown; a write to the timer this cycle takes precedence.
    for (int u = 0; u < NU; u++) begin
      if (actm_q[u] != '0 && !(dev == 2'b01 && fn == 2'b11 && s2 == 1'(u))) begin
        actm_d[u] = actm_q[u] - W'(1);
        if (actm_q[u] == W'(1)) acf_d[u] = '0;
      end
    end
`endif

    // Command decode; qualifiers are only examined where they matter.
    case (dev)
      2'b00: begin
        case (fn)
          2'b00: if (s5) frt_d[s2] = inp; else fgt_d[s2] = inp;
          2'b01: if (s5) frc_d[s2] = inp; else fgc_d[s2] = inp;
          2'b10: ice_d[s2] = inp[0];
          default: ;
        endcase
      end
      2'b01: begin
        case (fn)
          2'b00:   act_d[s2]  = inp;
          2'b01:   acc_d[s2]  = inp;
          2'b10:   acf_d[s2]  = inp;
          default: actm_d[s2] = inp;
        endcase
      end
      2'b10: begin
        if (!s3) begin
          if (!run_q[s2]) begin
            wsh_d[s2] = wash;
            rns_d[s2] = rinse;
            spn_d[s2] = spin;
            clo_d[s2] = cloth;
          end
        end else if (s5) begin
          run_d[s2] = 1'b0;
          wsh_d[s2] = '0;
          rns_d[s2] = '0;
          spn_d[s2] = '0;
          clo_d[s2] = '0;
        end else if (!run_q[s2]) begin
          run_d[s2] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    for (int u = 0; u < NU; u++) begin
      if (rst) begin
        fgt_q[u]  <= '0;
        frt_q[u]  <= '0;
        fgc_q[u]  <= '0;
        frc_q[u]  <= '0;
        ice_q[u]  <= 1'b0;
        act_q[u]  <= '0;
        acc_q[u]  <= '0;
        acf_q[u]  <= '0;
        actm_q[u] <= '0;
        wsh_q[u]  <= '0;
        rns_q[u]  <= '0;
        spn_q[u]  <= '0;
        clo_q[u]  <= '0;
        run_q[u]  <= 1'b0;
      end else begin
        fgt_q[u]  <= fgt_d[u];
        frt_q[u]  <= frt_d[u];
        fgc_q[u]  <= fgc_d[u];
        frc_q[u]  <= frc_d[u];
        ice_q[u]  <= ice_d[u];
        act_q[u]  <= act_d[u];
        acc_q[u]  <= acc_d[u];
        acf_q[u]  <= acf_d[u];
        actm_q[u] <= actm_d[u];
        wsh_q[u]  <= wsh_d[u];
        rns_q[u]  <= rns_d[u];
        spn_q[u]  <= spn_d[u];
        clo_q[u]  <= clo_d[u];
        run_q[u]  <= run_d[u];
      end
    end
  end

  assign fgt1 = fgt_q[0];  assign frt1 = frt_q[0];
  assign fgc1 = fgc_q[0];  assign frc1 = frc_q[0];
  assign fgt2 = fgt_q[1];  assign frt2 = frt_q[1];
  assign fgc2 = fgc_q[1];  assign frc2 = frc_q[1];
  assign ice1 = ice_q[0];  assign ice2 = ice_q[1];

  assign actemp1 = act_q[0];  assign accap1 = acc_q[0];
  assign acfan1  = acf_q[0];  assign actimer1 = actm_q[0];
  assign actemp2 = act_q[1];  assign accap2 = acc_q[1];
  assign acfan2  = acf_q[1];  assign actimer2 = actm_q[1];

  assign wash_out_1 = wsh_q[0];  assign rinse_out_1 = rns_q[0];
  assign spin_out_1 = spn_q[0];  assign cloth_out_1 = clo_q[0];
  assign wash_out_2 = wsh_q[1];  assign rinse_out_2 = rns_q[1];
  assign spin_out_2 = spn_q[1];  assign cloth_out_2 = clo_q[1];

endmodule

// File: tb/tb_home_appliance_ctrl.sv
// Testbench for home_appliance_ctrl: directed vector table, AC timer sequence,
// then randomized commands checked against an abstract model.
module tb_home_appliance_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       s0, s1, s2, s3, s4, s5;
  logic [4:0] inp, wash, rinse, spin, cloth;
  logic [4:0] fgt1, frt1, fgc1, frc1, fgt2, frt2, fgc2, frc2;
  logic       ice1, ice2;
  logic [4:0] actemp1, accap1, acfan1, actimer1, actemp2, accap2, acfan2, actimer2;
  logic [4:0] wash_out_1, rinse_out_1, spin_out_1, cloth_out_1;
  logic [4:0] wash_out_2, rinse_out_2, spin_out_2, cloth_out_2;

  home_appliance_ctrl #(.W(5)) dut (
    .clk(clk), .rst(rst),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5),
    .inp(inp),
    .fgt1(fgt1), .frt1(frt1), .fgc1(fgc1), .frc1(frc1),
    .fgt2(fgt2), .frt2(frt2), .fgc2(fgc2), .frc2(frc2),
    .ice1(ice1), .ice2(ice2),
    .actemp1(actemp1), .accap1(accap1), .acfan1(acfan1), .actimer1(actimer1),
    .actemp2(actemp2), .accap2(accap2), .acfan2(acfan2), .actimer2(actimer2),
    .wash(wash), .rinse(rinse), .spin(spin), .cloth(cloth),
    .wash_out_1(wash_out_1), .rinse_out_1(rinse_out_1),
    .spin_out_1(spin_out_1), .cloth_out_1(cloth_out_1),
    .wash_out_2(wash_out_2), .rinse_out_2(rinse_out_2),
    .spin_out_2(spin_out_2), .cloth_out_2(cloth_out_2)
  );

  always #5 clk = ~clk;

  // Output index map: 0-4 fridge1 (fgt,frt,fgc,frc,ice), 5-9 fridge2,
  // 10-13 AC1 (temp,cap,fan,timer), 14-17 AC2, 18-21 WM1 (wash,rinse,spin,cloth), 22-25 WM2.
  localparam int NO = 26;
  logic [4:0] dv [NO];
  assign dv[0] = fgt1;  assign dv[1] = frt1;  assign dv[2] = fgc1;  assign dv[3] = frc1;
  assign dv[4] = {4'b0, ice1};
  assign dv[5] = fgt2;  assign dv[6] = frt2;  assign dv[7] = fgc2;  assign dv[8] = frc2;
  assign dv[9] = {4'b0, ice2};
  assign dv[10] = actemp1; assign dv[11] = accap1; assign dv[12] = acfan1; assign dv[13] = actimer1;
  assign dv[14] = actemp2; assign dv[15] = accap2; assign dv[16] = acfan2; assign dv[17] = actimer2;
  assign dv[18] = wash_out_1; assign dv[19] = rinse_out_1;
  assign dv[20] = spin_out_1; assign dv[21] = cloth_out_1;
  assign dv[22] = wash_out_2; assign dv[23] = rinse_out_2;
  assign dv[24] = spin_out_2; assign dv[25] = cloth_out_2;

  string onames [NO] = '{"fgt1","frt1","fgc1","frc1","ice1","fgt2","frt2","fgc2","frc2","ice2",
                         "actemp1","accap1","acfan1","actimer1","actemp2","accap2","acfan2","actimer2",
                         "wash_out_1","rinse_out_1","spin_out_1","cloth_out_1",
                         "wash_out_2","rinse_out_2","spin_out_2","cloth_out_2"};

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit         r;
    logic [5:0] sel;   // {s0,s1,s2,s3,s4,s5}
    logic [4:0] v;
    logic [4:0] w, rs, sp, cl;
    int         idx;
    int         exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, logic [5:0] sel, logic [4:0] v, logic [4:0] w,
                              logic [4:0] rs, logic [4:0] sp, logic [4:0] cl, int idx, int exp);
    vec_t t;
    t.r = r; t.sel = sel; t.v = v; t.w = w; t.rs = rs; t.sp = sp; t.cl = cl;
    t.idx = idx; t.exp = exp;
    return t;
  endfunction

  task automatic drive(bit r, logic [5:0] sel, logic [4:0] v, logic [4:0] w,
                       logic [4:0] rs, logic [4:0] sp, logic [4:0] cl);
    rst = r;
    {s0, s1, s2, s3, s4, s5} = sel;
    inp = v; wash = w; rinse = rs; spin = sp; cloth = cl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Abstract model: settings as plain integers per unit.
  int m_fr  [2][4];
  int m_ice [2];
  int m_ac  [2][4];
  int m_wm  [2][4];
  bit m_run [2];

  function automatic void model_step(bit r, logic [5:0] sel, int v, int w, int rs, int sp, int cl);
    int  dev, u, fn;
    bit  q;
    bit  was_run [2];
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        m_ice[i] = 0; m_run[i] = 0;
        for (int k = 0; k < 4; k++) begin m_fr[i][k] = 0; m_ac[i][k] = 0; m_wm[i][k] = 0; end
      end
      return;
    end
    dev = int'(sel[5:4]); u = int'(sel[3]); fn = int'(sel[2:1]); q = sel[0];
    for (int i = 0; i < 2; i++) begin
      was_run[i] = m_run[i];
      if (m_run[i]) begin
        // first nonzero phase among wash, rinse, spin drains by one
        int ph = -1;
        for (int k = 2; k >= 0; k--) if (m_wm[i][k] > 0) ph = k;
        if (ph < 0) m_run[i] = 0;
        else m_wm[i][ph] = m_wm[i][ph] - 1;
      end
`ifdef AC_TIMER_EN
      if (m_ac[i][3] > 0 && !(dev == 1 && fn == 3 && u == i)) begin
        m_ac[i][3] = m_ac[i][3] - 1;
        if (m_ac[i][3] == 0) m_ac[i][2] = 0;
      end
`endif
    end
    if (dev == 0) begin
      if (fn == 2) m_ice[u] = v % 2;
      else if (fn < 2) m_fr[u][fn * 2 + (q ? 1 : 0)] = v;
    end else if (dev == 1) begin
      m_ac[u][fn] = v;
    end else if (dev == 2) begin
      if (fn < 2) begin
        if (!was_run[u]) begin m_wm[u][0] = w; m_wm[u][1] = rs; m_wm[u][2] = sp; m_wm[u][3] = cl; end
      end else if (q) begin
        m_run[u] = 0;
        for (int k = 0; k < 4; k++) m_wm[u][k] = 0;
      end else if (!was_run[u]) begin
        m_run[u] = 1;
      end
    end
  endfunction

  function automatic int model_out(int i);
    if (i < 10) return (i % 5 == 4) ? m_ice[i / 5] : m_fr[i / 5][i % 5];
    if (i < 18) return m_ac[(i - 10) / 4][(i - 10) % 4];
    return m_wm[(i - 18) / 4][(i - 18) % 4];
  endfunction

  initial begin
    drive(1'b1, 6'b110000, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);

    tbl.push_back(mk(1, 6'b110000, 5'd0,  0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(0, 6'b000100, 5'd0,  0, 0, 0, 0,  4, 0));
    tbl.push_back(mk(0, 6'b001100, 5'd0,  0, 0, 0, 0,  9, 0));
    tbl.push_back(mk(0, 6'b000000, 5'b10101, 0, 0, 0, 0, 0, 21));
    tbl.push_back(mk(0, 6'b110000, 5'd0,  0, 0, 0, 0,  1, 0));
    tbl.push_back(mk(0, 6'b001011, 5'b11111, 0, 0, 0, 0, 8, 31));
    tbl.push_back(mk(0, 6'b110000, 5'd0,  0, 0, 0, 0,  7, 0));
    tbl.push_back(mk(0, 6'b000100, 5'd1,  0, 0, 0, 0,  4, 1));
    tbl.push_back(mk(0, 6'b011100, 5'b01010, 0, 0, 0, 0, 16, 10));
    tbl.push_back(mk(0, 6'b110000, 5'd0,  0, 0, 0, 0, 12, 0));
    tbl.push_back(mk(0, 6'b010000, 5'd7,  0, 0, 0, 0, 10, 7));
    tbl.push_back(mk(0, 6'b000110, 5'd3,  0, 0, 0, 0,  0, 21));
    tbl.push_back(mk(0, 6'b100000, 5'd0, 31, 31, 31, 31, 18, 31));
    tbl.push_back(mk(0, 6'b110000, 5'd0,  0, 0, 0, 0, 21, 31));
    tbl.push_back(mk(0, 6'b100100, 5'd0,  0, 0, 0, 0, 18, 31));
    tbl.push_back(mk(0, 6'b110000, 5'd0,  0, 0, 0, 0, 18, 30));
    tbl.push_back(mk(0, 6'b100000, 5'd0,  1, 1, 1, 1, 18, 29));
    tbl.push_back(mk(0, 6'b100101, 5'd0,  0, 0, 0, 0, 18, 0));
    tbl.push_back(mk(0, 6'b110000, 5'd0,  0, 0, 0, 0, 21, 0));
    tbl.push_back(mk(0, 6'b100000, 5'd0,  2, 1, 1, 3, 18, 2));
    tbl.push_back(mk(0, 6'b100100, 5'd0,  0, 0, 0, 0, 18, 2));
    tbl.push_back(mk(0, 6'b110000, 5'd0,  0, 0, 0, 0, 18, 1));
    tbl.push_back(mk(0, 6'b110000, 5'd0,  0, 0, 0, 0, 18, 0));
    tbl.push_back(mk(0, 6'b110000, 5'd0,  0, 0, 0, 0, 19, 0));
    tbl.push_back(mk(0, 6'b110000, 5'd0,  0, 0, 0, 0, 20, 0));
    tbl.push_back(mk(0, 6'b110000, 5'd0,  0, 0, 0, 0, 21, 3));
    tbl.push_back(mk(0, 6'b100000, 5'd0,  5, 0, 0, 0, 18, 5));
    tbl.push_back(mk(0, 6'b101000, 5'd0,  4, 0, 0, 0, 22, 4));
    tbl.push_back(mk(0, 6'b101100, 5'd0,  0, 0, 0, 0, 22, 4));
    tbl.push_back(mk(0, 6'b110000, 5'd0,  0, 0, 0, 0, 22, 3));
    tbl.push_back(mk(1, 6'b110000, 5'd0,  0, 0, 0, 0, 22, 0));
    tbl.push_back(mk(0, 6'b110000, 5'd0,  0, 0, 0, 0,  0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].sel, tbl[i].v, tbl[i].w, tbl[i].rs, tbl[i].sp, tbl[i].cl);
      step();
      chk($sformatf("row%0d_%s", i, onames[tbl[i].idx]), int'(dv[tbl[i].idx]), tbl[i].exp);
    end

    // AC2 fan then timer=3 sequence.
    drive(0, 6'b011100, 5'b01010, 0, 0, 0, 0); step();
    chk("seq_acfan2_wr", int'(acfan2), 10);
    drive(0, 6'b011110, 5'd3, 0, 0, 0, 0); step();
    chk("seq_actimer2_wr", int'(actimer2), 3);
    drive(0, 6'b110000, 5'd0, 0, 0, 0, 0);
`ifdef AC_TIMER_EN
    step(); chk("seq_actimer2_c2", int'(actimer2), 2);
    chk("seq_acfan2_hold", int'(acfan2), 10);
    step(); chk("seq_actimer2_c1", int'(actimer2), 1);
    step(); chk("seq_actimer2_c0", int'(actimer2), 0);
    chk("seq_acfan2_clr", int'(acfan2), 0);
`else
    step(); step(); step();
    chk("seq_actimer2_hold", int'(actimer2), 3);
    chk("seq_acfan2_hold", int'(acfan2), 10);
`endif

    // Randomized commands against the model.
    drive(1, 6'b110000, 5'd0, 0, 0, 0, 0);
    step();
    model_step(1, 6'b110000, 0, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      bit         r;
      logic [5:0] sel;
      logic [4:0] v, w, rs, sp, cl;
      r   = ($urandom_range(0, 79) == 0);
      sel = 6'($urandom);
      if (sel[5:4] == 2'b10 && sel[2] && sel[0] && $urandom_range(0, 3) != 0) sel[0] = 1'b0;
      v   = 5'($urandom);
      w   = 5'($urandom_range(0, 7));
      rs  = 5'($urandom_range(0, 5));
      sp  = 5'($urandom_range(0, 5));
      cl  = 5'($urandom);
      drive(r, sel, v, w, rs, sp, cl);
      step();
      model_step(r, sel, int'(v), int'(w), int'(rs), int'(sp), int'(cl));
      for (int i = 0; i < NO; i++)
        chk($sformatf("rnd%0d_%s", n, onames[i]), int'(dv[i]), model_out(i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
